if_id_stage: RTL and testbench

Fetch-to-decode pipeline register for the 32-bit MIPS datapath with integrated load-use hazard detection. Captures the fetched instruction and PC+4, slices it into decode fields (the 16-bit immediate goes straight to the 32-bit sign-extension unit), and generates the one-cycle stall/bubble controls when the instruction in decode depends on a load in execute. It also handles the flush on a taken branch or jump and keeps a saturating stall counter for performance debug.

---
 rtl/if_id_stage.sv | 152 +++++++++++++++
 tb/tb_if_id_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// IF/ID pipeline register for the 32-bit MIPS datapath.
// Captures the fetched instruction and PC+4, slices decode fields, detects
// load-use hazards against the instruction in EX, and produces the one-cycle
// stall/bubble controls. A taken branch/jump flushes decode to a NOP.
// A saturating counter records stall cycles for performance debug.
module if_id_stage #(
    parameter int          DATA_W    = 32,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic [DATA_W-1:0] if_pc_plus4,
    input  logic              flush,
    input  logic              idex_valid,
    input  logic              idex_mem_read,
    input  logic [4:0]        idex_rt,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [DATA_W-1:0] id_pc_plus4,
    output logic [5:0]        id_opcode,
    output logic [4:0]        id_rs,
    output logic [4:0]        id_rt,
    output logic [4:0]        id_rd,
    output logic [4:0]        id_shamt,
    output logic [5:0]        id_funct,
    output logic [15:0]       id_imm16,
    output logic [25:0]       id_jaddr,
    output logic              pc_write_en,
    output logic              idex_bubble,
    output logic [CNT_W-1:0]  stall_count
);

    // Stall FSM: RUN may stall, HOLD lets the dependent instruction advance.
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Opcodes whose rt field is read as a source operand.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [0:0]        state_p1;
    logic [0:0]        state_next;
    logic              vld_p1;
    logic [31:0]       instr_p1;
    logic [DATA_W-1:0] pc_plus4_p1;
    logic [CNT_W-1:0]  stall_cnt_p1;

    logic              rt_is_src;
    logic              rs_match;
    logic              rt_match;
    logic              hazard;
    logic              stall;
    logic              count_en;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (val == {CNT_W{1'b1}}) begin
            return val;
        end
        return val + 1'b1;
    endfunction

    // Decode fields are pure slices of the registered instruction.
    assign id_valid    = vld_p1;
    assign id_instr    = instr_p1;
    assign id_pc_plus4 = pc_plus4_p1;
    assign id_opcode   = instr_p1[31:26];
    assign id_rs       = instr_p1[25:21];
    assign id_rt       = instr_p1[20:16];
    assign id_rd       = instr_p1[15:11];
    assign id_shamt    = instr_p1[10:6];
    assign id_funct    = instr_p1[5:0];
    assign id_imm16    = instr_p1[15:0];
    assign id_jaddr    = instr_p1[25:0];
    assign stall_count = stall_cnt_p1;

    // Hazard detection from registered decode state and same-cycle EX inputs.
    always_comb begin
        rt_is_src = 1'b0;
        case (id_opcode)
            OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: rt_is_src = 1'b1;
            default:                         rt_is_src = 1'b0;
        endcase
        rs_match = (idex_rt == id_rs);
        rt_match = rt_is_src & (idex_rt == id_rt);
        hazard   = vld_p1 & idex_valid & idex_mem_read & (idex_rt != 5'd0)
                 & (rs_match | rt_match);
    end

    // Stall only from RUN, so one load produces at most one stall cycle.
    always_comb begin
        stall       = (state_p1 == ST_RUN) & hazard;
        pc_write_en = ~stall;
        idex_bubble = stall;
        count_en    = stall & ~flush;
    end

    // Next FSM state; a flush always returns to RUN.
    always_comb begin
        state_next = ST_RUN;
        if (!flush && (state_p1 == ST_RUN) && stall) begin
            state_next = ST_HOLD;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_p1 <= ST_RUN;
        end else begin
            state_p1 <= state_next;
        end
    end

    // Valid and instruction: flush kills, stall holds, otherwise capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1   <= 1'b0;
            instr_p1 <= NOP_INSTR;
        end else if (flush) begin
            vld_p1   <= 1'b0;
            instr_p1 <= NOP_INSTR;
        end else if (!stall) begin
            vld_p1   <= if_valid;
            instr_p1 <= if_instr;
        end
    end

    // PC+4: left untouched by a flush, held across a stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_plus4_p1 <= '0;
        end else if (!flush && !stall) begin
            pc_plus4_p1 <= if_pc_plus4;
        end
    end

    // Stall cycle counter; flushed stalls are not counted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_p1 <= '0;
        end else if (count_en) begin
            stall_cnt_p1 <= sat_inc(stall_cnt_p1);
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed testbench for if_id_stage. The counter is instantiated 8 bits wide
// so saturation is reached in a few hundred cycles.
module tb_if_id_stage;

    localparam int CNT_W = 8;

    logic             clk;
    logic             reset_n;
    logic             if_valid;
    logic [31:0]      if_instr;
    logic [31:0]      if_pc_plus4;
    logic             flush;
    logic             idex_valid;
    logic             idex_mem_read;
    logic [4:0]       idex_rt;
    logic             id_valid;
    logic [31:0]      id_instr;
    logic [31:0]      id_pc_plus4;
    logic [5:0]       id_opcode;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       id_rd;
    logic [4:0]       id_shamt;
    logic [5:0]       id_funct;
    logic [15:0]      id_imm16;
    logic [25:0]      id_jaddr;
    logic             pc_write_en;
    logic             idex_bubble;
    logic [CNT_W-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ADDI   = 32'h2108FFFC; // addi $8,$8,-4
    localparam logic [31:0] ADD_RS = 32'h012B5020; // add $10,$9,$11
    localparam logic [31:0] ADD_R0 = 32'h000B5020; // add $10,$0,$11
    localparam logic [31:0] LW12   = 32'h8D2C0000; // lw $12,0($9)
    localparam logic [31:0] SW9    = 32'hAC890000; // sw $9,0($4)

    if_id_stage #(
        .DATA_W   (32),
        .CNT_W    (CNT_W),
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc_plus4  (if_pc_plus4),
        .flush        (flush),
        .idex_valid   (idex_valid),
        .idex_mem_read(idex_mem_read),
        .idex_rt      (idex_rt),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .id_pc_plus4  (id_pc_plus4),
        .id_opcode    (id_opcode),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .id_shamt     (id_shamt),
        .id_funct     (id_funct),
        .id_imm16     (id_imm16),
        .id_jaddr     (id_jaddr),
        .pc_write_en  (pc_write_en),
        .idex_bubble  (idex_bubble),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n       = 1'b0;
        if_valid      = 1'b0;
        if_instr      = 32'h0;
        if_pc_plus4   = 32'h0;
        flush         = 1'b0;
        idex_valid    = 1'b0;
        idex_mem_read = 1'b0;
        idex_rt       = 5'd0;

        // Reset state before any clock edge
        #2;
        chk("rst_valid", {31'b0, id_valid}, 32'h0);
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_pc", id_pc_plus4, 32'h0);
        chk("rst_cnt", {24'b0, stall_count}, 32'h0);
        chk("rst_pcwe", {31'b0, pc_write_en}, 32'h1);
        chk("rst_bubble", {31'b0, idex_bubble}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Pass-through of addi $8,$8,-4
        if_valid    = 1'b1;
        if_instr    = ADDI;
        if_pc_plus4 = 32'h0000_0104;
        step();
        chk("pt_imm16", {16'b0, id_imm16}, 32'h0000FFFC);
        chk("pt_rt", {27'b0, id_rt}, 32'd8);
        chk("pt_rs", {27'b0, id_rs}, 32'd8);
        chk("pt_opcode", {26'b0, id_opcode}, 32'h08);
        chk("pt_valid", {31'b0, id_valid}, 32'h1);
        chk("pt_pc", id_pc_plus4, 32'h0000_0104);
        chk("pt_pcwe", {31'b0, pc_write_en}, 32'h1);

        // Load-use: add $10,$9,$11 in ID, lw $9 in EX
        if_instr    = ADD_RS;
        if_pc_plus4 = 32'h0000_0108;
        step();
        chk("lu_funct", {26'b0, id_funct}, 32'h20);
        chk("lu_rd", {27'b0, id_rd}, 32'd10);
        idex_valid    = 1'b1;
        idex_mem_read = 1'b1;
        idex_rt       = 5'd9;
        if_instr      = ADDI;
        if_pc_plus4   = 32'h0000_010C;
        #1;
        chk("lu_pcwe", {31'b0, pc_write_en}, 32'h0);
        chk("lu_bubble", {31'b0, idex_bubble}, 32'h1);
        step();
        chk("lu_hold_instr", id_instr, ADD_RS);
        chk("lu_hold_pc", id_pc_plus4, 32'h0000_0108);
        chk("lu_cnt1", {24'b0, stall_count}, 32'd1);
        chk("lu_hold_pcwe", {31'b0, pc_write_en}, 32'h1);
        chk("lu_hold_bubble", {31'b0, idex_bubble}, 32'h0);
        step();
        chk("lu_adv_instr", id_instr, ADDI);
        chk("lu_adv_pc", id_pc_plus4, 32'h0000_010C);
        chk("lu_adv_cnt", {24'b0, stall_count}, 32'd1);
        chk("lu_adv_pcwe", {31'b0, pc_write_en}, 32'h1);

        // idex_rt=0 never stalls, even when rs is $0
        if_instr    = ADD_R0;
        if_pc_plus4 = 32'h0000_0110;
        step();
        idex_rt = 5'd0;
        #1;
        chk("nf_rt0_pcwe", {31'b0, pc_write_en}, 32'h1);
        // R-type reads rt: match on rt alone stalls
        idex_rt = 5'd11;
        #1;
        chk("rt_src_bubble", {31'b0, idex_bubble}, 32'h1);
        if_instr    = LW12;
        if_pc_plus4 = 32'h0000_0114;
        step();
        chk("rt_src_cnt", {24'b0, stall_count}, 32'd2);
        chk("rt_src_hold", id_instr, ADD_R0);
        idex_rt = 5'd12;
        step();
        // lw $12,0($9) in ID, load of $12 in EX: rt is not a source
        chk("nf_lw_instr", id_instr, LW12);
        chk("nf_lw_pcwe", {31'b0, pc_write_en}, 32'h1);

        // sw $9,0($4) reads rt
        if_instr    = SW9;
        if_pc_plus4 = 32'h0000_0118;
        step();
        idex_rt = 5'd9;
        #1;
        chk("sw_pcwe", {31'b0, pc_write_en}, 32'h0);

        // Flush in the same cycle as the hazard
        flush       = 1'b1;
        if_instr    = ADDI;
        if_pc_plus4 = 32'h0000_011C;
        #1;
        chk("fl_bubble_comb", {31'b0, idex_bubble}, 32'h1);
        step();
        flush = 1'b0;
        chk("fl_valid", {31'b0, id_valid}, 32'h0);
        chk("fl_instr", id_instr, 32'h0);
        chk("fl_pc", id_pc_plus4, 32'h0000_0118);
        chk("fl_cnt", {24'b0, stall_count}, 32'd2);
        chk("fl_pcwe", {31'b0, pc_write_en}, 32'h1);
        // FSM is RUN: reloading sw stalls immediately
        if_instr    = SW9;
        if_pc_plus4 = 32'h0000_0120;
        step();
        chk("fl_run_pcwe", {31'b0, pc_write_en}, 32'h0);

        // Asynchronous reset mid-stall
        reset_n = 1'b0;
        #1;
        chk("ar_valid", {31'b0, id_valid}, 32'h0);
        chk("ar_instr", id_instr, 32'h0);
        chk("ar_cnt", {24'b0, stall_count}, 32'd0);
        chk("ar_pcwe", {31'b0, pc_write_en}, 32'h1);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("ar_run_pcwe", {31'b0, pc_write_en}, 32'h0);

        // Saturation: one stall every two cycles with sw held in fetch
        for (int i = 0; i < 2; i++) step();
        chk("sat_cnt1", {24'b0, stall_count}, 32'd1);
        for (int i = 0; i < 506; i++) step();
        chk("sat_cnt254", {24'b0, stall_count}, 32'd254);
        for (int i = 0; i < 2; i++) step();
        chk("sat_cnt255", {24'b0, stall_count}, 32'hFF);
        for (int i = 0; i < 10; i++) step();
        chk("sat_hold", {24'b0, stall_count}, 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
